// File: rtl/lpf_tdm_sched.sv
`default_nettype none
// ============================================================================
// Module   : lpf_tdm_sched
// Purpose  : One TAPS-tap low-pass MAC engine shared round-robin by NCH streams
// Revision : 1.0 - initial release
// ============================================================================
module lpf_tdm_sched #(
  parameter int NCH   = 4,
  parameter int TAPS  = 8,
  parameter int DW    = 8,
  parameter int CW    = 4,
  parameter int SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_dat,
  output logic [NCH-1:0]    in_ready,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [CW-1:0]     cfg_wdata,
  output logic              cfg_ack,
  output logic              busy,
  output logic              out_valid,
  output logic [2:0]        out_ch,
  output logic [DW-1:0]     out_dat
);

  localparam int CHW = $clog2(NCH);
  localparam int KW  = $clog2(TAPS);
  localparam int AW  = DW + CW + KW;
  localparam logic [AW-1:0] SAT = AW'((1 << DW) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MAC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]  hist [NCH][TAPS];
  logic [CW-1:0]  coef [TAPS];
  logic [CHW-1:0] ptr;
  logic [CHW-1:0] ch;
  logic [DW-1:0]  sample;
  logic [AW-1:0]  acc;
  logic [KW-1:0]  tap;

  logic           grant_vld;
  logic [CHW-1:0] grant;
  logic [CHW:0]   idx;
  logic [DW-1:0]  sel_dat;
  logic           xfer;
  logic           cfg_commit;
  logic           last_tap;
  logic [AW-1:0]  acc_nxt;
  logic [AW-1:0]  acc_shr;

  // First requester at or after ptr, wrapping modulo NCH.
  always_comb begin
    grant_vld = 1'b0;
    grant     = ptr;
    idx       = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = {1'b0, ptr} + (CHW+1)'(i);
      if (idx >= (CHW+1)'(NCH)) idx = idx - (CHW+1)'(NCH);
      if (!grant_vld && in_valid[idx[CHW-1:0]]) begin
        grant_vld = 1'b1;
        grant     = idx[CHW-1:0];
      end
    end
  end

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == CHW'(i)) sel_dat = in_dat[i*DW +: DW];
    end
  end

  always_comb begin
    in_ready = '0;
    if (state == S_IDLE && grant_vld) in_ready[grant] = 1'b1;
  end

  assign xfer       = (state == S_IDLE) && grant_vld;
  assign cfg_commit = (state == S_IDLE) && !grant_vld && cfg_we;
  assign last_tap   = (tap == KW'(TAPS - 1));
  assign acc_nxt    = acc + AW'(hist[ch][tap]) * AW'(coef[tap]);
  assign acc_shr    = acc_nxt >> SHIFT;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_vld) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_MAC;
      S_MAC:   if (last_tap) state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      ch        <= '0;
      sample    <= '0;
      acc       <= '0;
      tap       <= '0;
      cfg_ack   <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_dat   <= '0;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < TAPS; k++)
          hist[c][k] <= '0;
      for (int k = 0; k < TAPS; k++)
        coef[k] <= CW'(1);
    end else begin
      cfg_ack   <= cfg_commit;
      out_valid <= 1'b0;
      // Out-of-range tap addresses are still acknowledged so the source never stalls.
      if (cfg_commit && (int'(cfg_addr) < TAPS))
        coef[KW'(cfg_addr)] <= cfg_wdata;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            ch     <= grant;
            sample <= sel_dat;
            ptr    <= (grant == CHW'(NCH - 1)) ? '0 : grant + CHW'(1);
          end
        end
        S_LOAD: begin
          hist[ch][0] <= sample;
          for (int k = 1; k < TAPS; k++)
            hist[ch][k] <= hist[ch][k-1];
          acc <= '0;
          tap <= '0;
        end
        S_MAC: begin
          acc <= acc_nxt;
          tap <= tap + KW'(1);
          if (last_tap) begin
            out_valid <= 1'b1;
            out_ch    <= 3'(ch);
            out_dat   <= (acc_shr > SAT) ? {DW{1'b1}} : acc_shr[DW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lpf_tdm_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_lpf_tdm_sched
// Purpose  : Randomised scoreboard bench for the shared low-pass MAC scheduler
// Revision : 1.0 - initial release
// ============================================================================
module tb_lpf_tdm_sched;

  localparam int NCH   = 4;
  localparam int TAPS  = 8;
  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int SHIFT = 3;
  localparam int LAT   = TAPS + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    in_valid = '0;
  logic [NCH*DW-1:0] in_dat = '0;
  logic [NCH-1:0]    in_ready;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_addr = '0;
  logic [CW-1:0]     cfg_wdata = '0;
  logic              cfg_ack;
  logic              busy;
  logic              out_valid;
  logic [2:0]        out_ch;
  logic [DW-1:0]     out_dat;

  lpf_tdm_sched #(.NCH(NCH), .TAPS(TAPS), .DW(DW), .CW(CW), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_dat(in_dat), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack),
    .busy(busy), .out_valid(out_valid), .out_ch(out_ch), .out_dat(out_dat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endfunction

  // Reference model: per-channel histories, shared coefficients, rotating priority.
  typedef struct { int ch; int dat; int cyc; } exp_t;
  exp_t sb[$];
  exp_t e;
  int mhist [NCH][TAPS];
  int mcoef [TAPS];
  int mptr     = 0;
  int next_ok  = 0;
  int last_acc = -100;
  int ack_cyc  = -1;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < TAPS; k++) mhist[c][k] = 0;
    for (int k = 0; k < TAPS; k++) mcoef[k] = 1;
    mptr     = 0;
    last_acc = -100;
    ack_cyc  = -1;
    sb.delete();
  endfunction

  function automatic void accept(int g, int smp);
    exp_t x;
    int   s;
    for (int k = TAPS - 1; k > 0; k--) mhist[g][k] = mhist[g][k-1];
    mhist[g][0] = smp;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += mhist[g][k] * mcoef[k];
    s = s >> SHIFT;
    if (s > (1 << DW) - 1) s = (1 << DW) - 1;
    x.ch = g; x.dat = s; x.cyc = cyc + LAT;
    sb.push_back(x);
    mptr     = (g + 1) % NCH;
    last_acc = cyc;
    next_ok  = cyc + LAT + 1;
  endfunction

  logic [NCH-1:0] er;
  int             g;
  bit             idle;

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      next_ok = cyc + 1;
    end else begin
      chk("busy", 32'(busy), 32'(cyc > last_acc && cyc <= last_acc + LAT));
      chk("cfg_ack", 32'(cfg_ack), 32'(cyc == ack_cyc));
      if (out_valid) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("out_ch", 32'(out_ch), 32'(e.ch));
          chk("out_dat", 32'(out_dat), 32'(e.dat));
          chk("out_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("missing_out_valid", 32'd0, 32'd1);
      end
      idle = (cyc >= next_ok);
      er   = '0;
      g    = -1;
      if (idle)
        for (int i = 0; i < NCH; i++)
          if (g < 0 && in_valid[(mptr + i) % NCH]) g = (mptr + i) % NCH;
      if (g >= 0) er[g] = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(er));
      if (g >= 0) accept(g, int'(in_dat[g*DW +: DW]));
      else if (idle && cfg_we) begin
        if (int'(cfg_addr) < TAPS) mcoef[cfg_addr] = int'(cfg_wdata);
        ack_cyc = cyc + 1;
      end
    end
  end

  task automatic send(int ch, int val);
    bit got = 0;
    in_valid = '0;
    in_valid[ch] = 1'b1;
    in_dat[ch*DW +: DW] = DW'(val);
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (in_ready[ch]) got = 1;
    end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
    in_valid = '0;
  endtask

  task automatic cfg_write(int a, int d);
    bit got = 0;
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_wdata = CW'(d);
    for (int n = 0; n < 60 && !got; n++) begin
      @(posedge clk); #2;
      if (cfg_ack) got = 1;
    end
    if (!got) chk("cfg_timeout", 32'd0, 32'd1);
    cfg_we = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_ch"},    32'(out_ch),    32'd0);
    chk({tag, "_out_dat"},   32'(out_dat),   32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_cfg_ack"},   32'(cfg_ack),   32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check_reset_outputs("reset");
    @(posedge clk); #2;

    // Constant 80 on ch0 ramps the output 10,20,...,80.
    for (int i = 0; i < TAPS; i++) send(0, 80);

    // All channels requesting: strict rotation.
    in_valid = '1;
    repeat (70) begin
      in_dat = (NCH*DW)'($urandom);
      @(posedge clk); #2;
    end
    in_valid = '0;
    repeat (12) @(posedge clk); #2;

    // Priority pointer wraps back to a lower channel.
    send(2, 5);
    send(2, 6);

    // Saturation with a single large coefficient; ch2 history preserved.
    cfg_write(0, 15);
    for (int k = 1; k < TAPS; k++) cfg_write(k, 0);
    send(1, 200);
    send(2, 50);

    // Write held across a job: commits only after OUT.
    send(0, 50);
    cfg_write(0, 1);
    send(0, 30);
    repeat (12) @(posedge clk); #2;

    // Reset in the middle of MAC aborts the job.
    send(1, 100);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    check_reset_outputs("midjob_reset");
    @(posedge clk); #2;
    send(3, 8);
    repeat (12) @(posedge clk); #2;

    // Random traffic with interleaved coefficient writes.
    for (int n = 0; n < 900; n++) begin
      in_valid = NCH'($urandom) & NCH'($urandom | (n[7] ? 32'hF : 32'h0));
      in_dat   = (NCH*DW)'($urandom);
      if (cfg_we && cfg_ack) cfg_we = 1'b0;
      else if (!cfg_we && $urandom_range(0, 9) == 0) begin
        cfg_we    = 1'b1;
        cfg_addr  = 3'($urandom_range(0, 7));
        cfg_wdata = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15))
                                                : CW'($urandom_range(0, 2));
      end
      @(posedge clk); #2;
    end
    in_valid = '0;
    cfg_we   = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
